// File: rtl/bit_reverse_reorder_if.sv
// bit_reverse_reorder_if: input and output streams of bit_reverse_reorder.
// slave is the reorder block, master is the surrounding logic.
// With REORDER_ERR_EN defined, the interface also carries the sticky err flag.
interface bit_reverse_reorder_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 16
);
    localparam int AW = $clog2(N);

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } complex_product_t;

    logic             in_valid;
    complex_product_t in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    complex_product_t out_data;
    logic [AW-1:0]    out_index;
    logic             out_last;
`ifdef REORDER_ERR_EN
    logic             err;
`endif

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
`ifdef REORDER_ERR_EN
        , output err
`endif
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
`ifdef REORDER_ERR_EN
        , input err
`endif
    );
endinterface

// File: rtl/bit_reverse_reorder.sv
// bit_reverse_reorder: turns frames of N complex samples that arrive in
// bit-reversed order into natural order, using two ping-pong banks so that
// one frame can be written while the previous one drains.
// Optional feature: define REORDER_ERR_EN to add the sticky drop flag bus.err.
//
// bank state | meaning
// EMPTY      | holds nothing, may be written
// FILLING    | part of a frame written, wc < N
// DRAINING   | complete frame held, read out in natural order
module bit_reverse_reorder #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    bit_reverse_reorder_if.slave bus
);
    localparam int            AW   = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } complex_product_t;

    typedef enum logic [1:0] {EMPTY, FILLING, DRAINING} bank_state_t;

    complex_product_t mem [2][N];
    bank_state_t      bank_state [2];
    bank_state_t      bank_next [2];

    logic             wr_bank;
    logic             rd_bank;
    logic [AW-1:0]    wc;
    logic [AW-1:0]    rc;

    logic             in_ready;
    logic             accept;
    logic             load_en;
    logic             read_go;
    logic             read_done;

    logic             out_valid_q;
    complex_product_t out_data_q;
    logic [AW-1:0]    out_index_q;
    logic             out_last_q;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    assign in_ready  = (bank_state[wr_bank] != DRAINING);
    assign accept    = bus.in_valid && in_ready;
    assign load_en   = !out_valid_q || bus.out_ready;
    assign read_go   = (bank_state[rd_bank] == DRAINING) && load_en;
    assign read_done = read_go && (rc == LAST);

    // Bank state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
        end else begin
            bank_state[0] <= bank_next[0];
            bank_state[1] <= bank_next[1];
        end
    end

    // Bank next state: reading and writing never target the same bank in
    // one cycle, because a bank is only read while DRAINING and only
    // written while not DRAINING.
    always_comb begin
        bank_next[0] = bank_state[0];
        bank_next[1] = bank_state[1];
        for (int b = 0; b < 2; b++) begin
            if (read_done && (rd_bank == 1'(b))) begin
                bank_next[b] = EMPTY;
            end else if (accept && (wr_bank == 1'(b))) begin
                bank_next[b] = (wc == LAST) ? DRAINING : FILLING;
            end
        end
    end

    // Write/read pointers and counters; the counters wrap because N is a power of 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wc      <= '0;
            rc      <= '0;
        end else begin
            if (accept) begin
                wc <= wc + 1'b1;
                if (wc == LAST) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (read_go) begin
                rc <= rc + 1'b1;
                if (rc == LAST) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end

    // Sample memory: the k-th sample of a frame lands at its natural index.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank][bitrev(wc)] <= complex_product_t'(bus.in_data);
        end
    end

    // Output register: loads when empty or being consumed, otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else if (read_go) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mem[rd_bank][rc];
            out_index_q <= rc;
            out_last_q  <= (rc == LAST);
        end else if (load_en) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;

`ifdef REORDER_ERR_EN
    logic err_q;

    // Sticky flag: set once any offered sample is refused.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (bus.in_valid && !in_ready) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif
endmodule
